// File: rtl/regfile_bist_pkg.sv
// Shared types, test patterns and the expected-value helper for the register-file self-test.
package regfile_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] PAT0 = 32'h5555_5555;
  localparam logic [31:0] PAT1 = 32'hAAAA_AAAA;

  // Address-unique write pattern: the pass pattern with the register address folded into the low bits.
  function automatic logic [31:0] pat_data(input logic p, input logic [31:0] a);
    return (p ? PAT1 : PAT0) ^ a;
  endfunction

  // Value a healthy regfile should return; a hardwired register 0 always reads back as zero.
  function automatic logic [31:0] exp_data(input logic p, input logic [31:0] a, input logic zero_reg);
    return (zero_reg && (a == 32'd0)) ? 32'd0 : pat_data(p, a);
  endfunction

endpackage

// File: rtl/regfile_bist.sv
// Self-test initiator for a 2-read/1-write register file. It writes an address-unique pattern to
// every register and reads it back on both ports. This repeats for two complementary patterns,
// and the unit then reports a mismatch count and the first failing address.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW-1:0] o_err_addr,
  output logic [7:0]    o_err_count,
  output logic          o_we3,
  output logic [AW-1:0] o_wa3,
  output logic [DW-1:0] o_wd3,
  output logic [AW-1:0] o_ra1,
  output logic [AW-1:0] o_ra2,
  input  logic [DW-1:0] i_rd1,
  input  logic [DW-1:0] i_rd2
);

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_a;
  logic          r_p;
  logic [7:0]    r_errCount;
  logic [AW-1:0] r_errAddr;

  logic          w_lastAddr;
  logic [AW-1:0] w_ra2;
  logic [DW-1:0] w_exp1;
  logic [DW-1:0] w_exp2;
  logic          w_mis1;
  logic          w_mis2;
  logic [8:0]    w_errSum;
  logic [7:0]    w_errNext;

  assign w_lastAddr = (r_a == AW'(NREGS - 1));
  assign w_ra2      = AW'(NREGS - 1) - r_a;
  assign w_exp1     = DW'(exp_data(r_p, 32'(r_a), ZERO_REG));
  assign w_exp2     = DW'(exp_data(r_p, 32'(w_ra2), ZERO_REG));
  assign w_mis1     = (r_state == READ) && (i_rd1 != w_exp1);
  assign w_mis2     = (r_state == READ) && (i_rd2 != w_exp2);
  assign w_errSum   = {1'b0, r_errCount} + 9'(w_mis1) + 9'(w_mis2);
  assign w_errNext  = (w_errSum > 9'd255) ? 8'hFF : w_errSum[7:0];

  // State register; reset aborts any run immediately.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Sequencing: start only counts when idle or finished; each phase walks all addresses once.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = WRITE;
      WRITE:   if (w_lastAddr) w_nextState = READ;
      READ:    if (w_lastAddr) w_nextState = r_p ? DONE : WRITE;
      DONE:    if (i_start) w_nextState = WRITE;
      default: w_nextState = IDLE;
    endcase
  end

  // Address walker, pass bit and error bookkeeping. The first error is detected while the count is
  // still zero, which is safe because the count saturates instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a        <= '0;
      r_p        <= 1'b0;
      r_errCount <= '0;
      r_errAddr  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_a        <= '0;
            r_p        <= 1'b0;
            r_errCount <= '0;
            r_errAddr  <= '0;
          end
        end
        WRITE: begin
          r_a <= w_lastAddr ? '0 : r_a + 1'b1;
        end
        READ: begin
          r_errCount <= w_errNext;
          if ((r_errCount == 8'd0) && (w_mis1 || w_mis2)) begin
            r_errAddr <= w_mis1 ? r_a : w_ra2;
          end
          if (w_lastAddr) begin
            r_a <= '0;
            if (!r_p) r_p <= 1'b1;
          end else begin
            r_a <= r_a + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Port drive and status, decoded purely from registered state so read data never reaches outputs.
  always_comb begin
    o_we3 = 1'b0;
    o_wa3 = '0;
    o_wd3 = '0;
    o_ra1 = '0;
    o_ra2 = '0;
    if (r_state == WRITE) begin
      o_we3 = 1'b1;
      o_wa3 = r_a;
      o_wd3 = DW'(pat_data(r_p, 32'(r_a)));
    end
    if (r_state == READ) begin
      o_ra1 = r_a;
      o_ra2 = w_ra2;
    end
    o_busy      = (r_state == WRITE) || (r_state == READ);
    o_done      = (r_state == DONE);
    o_pass      = (r_state == DONE) && (r_errCount == 8'd0);
    o_err_addr  = r_errAddr;
    o_err_count = r_errCount;
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: a behavioural regfile with selectable faults, a reference model of the
// whole test run, and a monitor that scores each completed run and every port-drive cycle.
module tb_regfile_bist;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, pass, we3;
  logic [4:0]  errAddr, wa3, ra1, ra2;
  logic [7:0]  errCount;
  logic [31:0] wd3, rd1, rd2;

  // 0: healthy regfile, 1: reg 9 bit 7 stuck-at-1, 2: register 0 writable.
  int          faultMode;
  logic [31:0] mem [N];

  typedef struct {
    int errCount;
    int errAddr;
    bit pass;
    int busyLen;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;

  regfile_bist dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_err_addr  (errAddr),
    .o_err_count (errCount),
    .o_we3       (we3),
    .o_wa3       (wa3),
    .o_wd3       (wd3),
    .o_ra1       (ra1),
    .o_ra2       (ra2),
    .i_rd1       (rd1),
    .i_rd2       (rd2)
  );

  always #5 clk = ~clk;

  // Regfile write port; register 0 ignores writes unless the writable-zero fault is selected.
  always @(posedge clk) begin
    if (we3 && !(faultMode != 2 && wa3 == 5'd0)) mem[wa3] <= wd3;
  end

  assign rd1 = ((ra1 == 5'd0 && faultMode != 2) ? 32'd0 : mem[ra1]) |
               ((faultMode == 1 && ra1 == 5'd9) ? 32'h0000_0080 : 32'd0);
  assign rd2 = ((ra2 == 5'd0 && faultMode != 2) ? 32'd0 : mem[ra2]) |
               ((faultMode == 1 && ra2 == 5'd9) ? 32'h0000_0080 : 32'd0);

  function automatic logic [31:0] patOf(int p, int a);
    logic [31:0] base;
    base = (p != 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    return base ^ 32'(a);
  endfunction

  // Outcome of a whole run: what each register holds after the write sweep, what each read returns,
  // and which reads disagree with the healthy value. Port 1 is considered before port 2 in a cycle.
  function automatic expect_t refRun(int mode);
    expect_t     e;
    int          cnt   = 0;
    int          first = -1;
    int          addr;
    logic [31:0] stored;
    logic [31:0] want;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N; a++) begin
        for (int port = 0; port < 2; port++) begin
          addr   = (port == 0) ? a : N - 1 - a;
          stored = (addr == 0 && mode != 2) ? 32'd0 : patOf(p, addr);
          if (mode == 1 && addr == 9) stored = stored | 32'h0000_0080;
          want = (addr == 0) ? 32'd0 : patOf(p, addr);
          if (stored != want) begin
            cnt++;
            if (first < 0) first = addr;
          end
        end
      end
    end
    e.errCount = (cnt > 255) ? 255 : cnt;
    e.errAddr  = (first < 0) ? 0 : first;
    e.pass     = (cnt == 0);
    e.busyLen  = 4 * N;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: checks the port sequence each busy cycle, idle port quietness, and scores each run on done.
  int busyCnt = 0;
  bit prevDone = 1'b0;
  always begin
    logic [47:0] portVec;
    logic [47:0] wantVec;
    int          ph;
    int          idx;
    int          pp;
    expect_t     e;
    @(posedge clk);
    #1;
    portVec = {we3, wa3, wd3, ra1, ra2};
    if (reset) begin
      busyCnt  = 0;
      prevDone = 1'b0;
    end else begin
      if (busy) begin
        ph  = busyCnt / N;
        idx = busyCnt % N;
        pp  = ph / 2;
        if (ph % 2 == 0) wantVec = {1'b1, 5'(idx), patOf(pp, idx), 5'd0, 5'd0};
        else             wantVec = {1'b0, 5'd0, 32'd0, 5'(idx), 5'(N - 1 - idx)};
        checkOutput($sformatf("portSeq[%0d]", busyCnt), 64'(portVec), 64'(wantVec));
        busyCnt++;
      end else begin
        checkOutput("idlePorts", 64'(portVec), 64'd0);
      end
      if (done && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 64'(done), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("busyLen", 64'(busyCnt), 64'(e.busyLen));
          checkOutput("errCount", 64'(errCount), 64'(e.errCount));
          checkOutput("errAddr", 64'(errAddr), 64'(e.errAddr));
          checkOutput("pass", 64'(pass), 64'(e.pass));
        end
        busyCnt = 0;
      end
      prevDone = done;
    end
  end

  task automatic waitDone(input int midStart);
    int n = 0;
    while (!done && n < 400) begin
      start = (n == midStart);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("doneTimeout", 64'(done), 64'd1);
    if (!done) expQ.delete();
  endtask

  task automatic applyStimulus(input int mode, input int midStart);
    faultMode = mode;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    expQ.push_back(refRun(mode));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(midStart);
  endtask

  task automatic resetMidRun();
    faultMode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    checkOutput("busyBeforeReset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortState", 64'({busy, done, we3}), 64'd0);
    reset = 1'b0;
  endtask

  task automatic heldStart();
    int n = 0;
    expQ.push_back(refRun(1));
    expQ.push_back(refRun(0));
    faultMode = 1;
    start = 1'b1;
    @(negedge clk);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("heldDone", 64'(done), 64'd1);
    faultMode = 0;
    @(negedge clk);
    checkOutput("heldRestart", 64'({busy, done}), 64'b10);
    checkOutput("heldErrCleared", 64'(errCount), 64'd0);
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitDone(-1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    faultMode = 0;
    for (int i = 0; i < N; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("resetState", 64'({busy, done, pass, we3, errCount, errAddr, wa3, wd3, ra1, ra2}), 64'd0);
    reset = 1'b0;

    applyStimulus(0, -1);
    applyStimulus(1, -1);
    applyStimulus(2, -1);
    resetMidRun();
    applyStimulus(0, -1);
    applyStimulus(0, int'($urandom_range(10, 120)));
    heldStart();
    for (int r = 0; r < 4; r++) applyStimulus(int'($urandom_range(0, 2)), -1);

    repeat (5) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
